// File: rtl/tile_match_engine_if.sv
// Board RAM port pair: the engine drives addresses and write strobes, the RAM returns read data.
interface tile_match_engine_if #(
  parameter int AW     = 4,
  parameter int DATA_W = 8
);
  logic [AW-1:0]     addrA, addrB;
  logic              weA, weB;
  logic [DATA_W-1:0] writeA, writeB, readA, readB;

  modport master (output addrA, addrB, weA, weB, writeA, writeB, input readA, readB);
  modport slave  (input addrA, addrB, weA, weB, writeA, writeB, output readA, readB);
endinterface

// File: rtl/tile_match_engine.sv
// In-game controller for the tile-matching game: cursor moves, picks, reveal delay and pair resolve.
// RAM ops wait RD_LAT cycles after the address; write strobes are gated by quit in the write cycle.
module tile_match_engine #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int DATA_W        = 8,
  parameter int RD_LAT        = 2,
  parameter int REVEAL_CYCLES = 100000000,
  parameter int SCORE_W       = 8,
  parameter int WRAP          = 1,
  localparam int N            = ROWS * COLS,
  localparam int AW           = $clog2(N),
  localparam int PAIRS        = N / 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inGameOn,
  input  logic               userquit,
  input  logic               arrowUp,
  input  logic               arrowDown,
  input  logic               arrowL,
  input  logic               arrowR,
  input  logic               select,
  tile_match_engine_if.master ram,
  output logic [SCORE_W-1:0] score,
  output logic [AW-1:0]      matched,
  output logic               gameOver,
  output logic               busy,
  output logic [3:0]         state
);
  localparam int CW = $clog2(REVEAL_CYCLES + RD_LAT + 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, SELECT = 4'd1, MOVE_RD = 4'd2, MOVE_WR = 4'd3, PICK_RD = 4'd4,
    PICK_WR = 4'd5, REVEAL = 4'd6, RESOLVE = 4'd7, DONE = 4'd8
  } state_t;

  state_t            st;
  logic [AW-1:0]     cursor, addr_a, addr_b, loc1, loc2, mv_dst;
  logic [DATA_W-3:0] id1, id2;
  logic              first, quit, ids_eq, mv_go, we_a, we_b;
  logic [CW-1:0]     cnt;
  logic [4:0]        btn, btn_q, pulse;
  logic [DATA_W-1:0] wr_a, wr_b;
  int                cur_i, cur_row, cur_col;

  assign btn      = {select, arrowUp, arrowDown, arrowL, arrowR};
  assign pulse    = btn & ~btn_q;
  assign quit     = userquit | ~inGameOn;
  assign ids_eq   = (id1 == id2);
  assign state    = st;
  assign gameOver = (st == DONE);
  assign busy     = !((st == IDLE) || (st == SELECT) || (st == DONE));

  assign ram.addrA  = addr_a;
  assign ram.addrB  = addr_b;
  assign ram.weA    = we_a;
  assign ram.weB    = we_b;
  assign ram.writeA = wr_a;
  assign ram.writeB = wr_b;

  // Destination of an arrow press; mv_go stays low when the cursor is clamped at an edge.
  always_comb begin
    mv_go   = 1'b0;
    mv_dst  = cursor;
    cur_i   = int'(cursor);
    cur_row = cur_i / COLS;
    cur_col = cur_i % COLS;
    if (pulse[3]) begin
      if (cur_row != 0) begin mv_go = 1'b1; mv_dst = AW'(cur_i - COLS); end
      else if (WRAP != 0) begin mv_go = 1'b1; mv_dst = AW'((ROWS - 1) * COLS + cur_col); end
    end else if (pulse[2]) begin
      if (cur_row != ROWS - 1) begin mv_go = 1'b1; mv_dst = AW'(cur_i + COLS); end
      else if (WRAP != 0) begin mv_go = 1'b1; mv_dst = AW'(cur_col); end
    end else if (pulse[1]) begin
      if (cur_col != 0) begin mv_go = 1'b1; mv_dst = AW'(cur_i - 1); end
      else if (WRAP != 0) begin mv_go = 1'b1; mv_dst = AW'(cur_i + COLS - 1); end
    end else if (pulse[0]) begin
      if (cur_col != COLS - 1) begin mv_go = 1'b1; mv_dst = AW'(cur_i + 1); end
      else if (WRAP != 0) begin mv_go = 1'b1; mv_dst = AW'(cur_i - (COLS - 1)); end
    end
  end

  // Write data depends on the read data arriving in the write cycle itself.
  always_comb begin
    we_a = 1'b0;
    we_b = 1'b0;
    wr_a = '0;
    wr_b = '0;
    case (st)
      MOVE_WR: begin
        wr_a = ram.readA & ~DATA_W'(1);
        wr_b = ram.readB | DATA_W'(1);
        we_a = ~quit;
        we_b = ~quit;
      end
      PICK_WR: begin
        wr_a = ram.readA | DATA_W'(2);
        we_a = ~quit & ~ram.readA[1];
      end
      RESOLVE: begin
        wr_a = {id1, 1'b0, (loc1 == cursor)};
        wr_b = {id2, 1'b0, (loc2 == cursor)};
        we_a = ~quit & ~ids_eq;
        we_b = ~quit & ~ids_eq;
      end
      default: begin end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      cursor  <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      loc1    <= '0;
      loc2    <= '0;
      id1     <= '0;
      id2     <= '0;
      first   <= 1'b0;
      cnt     <= '0;
      btn_q   <= '0;
      score   <= '0;
      matched <= '0;
    end else begin
      btn_q <= btn;
      case (st)
        IDLE: begin
          cursor  <= '0;
          score   <= '0;
          matched <= '0;
          first   <= 1'b0;
          if (!quit) st <= SELECT;
        end
        SELECT: begin
          if (pulse[4]) begin
            addr_a <= cursor;
            cnt    <= CW'(RD_LAT - 1);
            st     <= PICK_RD;
          end else if (mv_go) begin
            addr_a <= cursor;
            addr_b <= mv_dst;
            cnt    <= CW'(RD_LAT - 1);
            st     <= MOVE_RD;
          end
        end
        MOVE_RD: if (cnt == '0) st <= MOVE_WR; else cnt <= cnt - CW'(1);
        MOVE_WR: begin
          cursor <= addr_b;
          st     <= SELECT;
        end
        PICK_RD: if (cnt == '0) st <= PICK_WR; else cnt <= cnt - CW'(1);
        PICK_WR: begin
          if (ram.readA[1]) begin
            st <= SELECT;
          end else if (!first) begin
            id1   <= ram.readA[DATA_W-1:2];
            loc1  <= addr_a;
            first <= 1'b1;
            st    <= SELECT;
          end else begin
            id2  <= ram.readA[DATA_W-1:2];
            loc2 <= addr_a;
            cnt  <= CW'(REVEAL_CYCLES - 1);
            st   <= REVEAL;
          end
        end
        REVEAL: begin
          if (cnt == '0) begin
            addr_a <= loc1;
            addr_b <= loc2;
            st     <= RESOLVE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESOLVE: begin
          if (score != '1) score <= score + SCORE_W'(1);
          first <= 1'b0;
          if (ids_eq) begin
            matched <= matched + AW'(1);
            st      <= (matched == AW'(PAIRS - 1)) ? DONE : SELECT;
          end else begin
            st <= SELECT;
          end
        end
        DONE:    if (quit) st <= IDLE;
        default: st <= IDLE;
      endcase
      // Abort wins over whatever the case above scheduled; IDLE then clears the game state.
      if (quit && (st != DONE)) st <= IDLE;
    end
  end
endmodule

// File: tb/tb_tile_match_engine.sv
// Directed bench: 4x4 board, RD_LAT=2, REVEAL_CYCLES=4; a WRAP=1 engine on a RAM model plus a WRAP=0 engine.
module tb_tile_match_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inGameOn = 1'b0, userquit = 1'b0;
  logic arrowUp = 1'b0, arrowDown = 1'b0, arrowL = 1'b0, arrowR = 1'b0, select = 1'b0;

  tile_match_engine_if #(.AW(4), .DATA_W(8)) ram1 ();
  tile_match_engine_if #(.AW(4), .DATA_W(8)) ram2 ();

  logic [7:0] score1, score2;
  logic [3:0] matched1, matched2, state1, state2;
  logic       go1, go2, busy1, busy2;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  tile_match_engine #(.ROWS(4), .COLS(4), .DATA_W(8), .RD_LAT(2), .REVEAL_CYCLES(4),
                      .SCORE_W(8), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .inGameOn(inGameOn), .userquit(userquit),
    .arrowUp(arrowUp), .arrowDown(arrowDown), .arrowL(arrowL), .arrowR(arrowR),
    .select(select), .ram(ram1), .score(score1), .matched(matched1),
    .gameOver(go1), .busy(busy1), .state(state1));

  tile_match_engine #(.ROWS(4), .COLS(4), .DATA_W(8), .RD_LAT(2), .REVEAL_CYCLES(4),
                      .SCORE_W(8), .WRAP(0)) u_clamp (
    .clk(clk), .reset(reset), .inGameOn(inGameOn), .userquit(userquit),
    .arrowUp(arrowUp), .arrowDown(arrowDown), .arrowL(arrowL), .arrowR(arrowR),
    .select(select), .ram(ram2), .score(score2), .matched(matched2),
    .gameOver(go2), .busy(busy2), .state(state2));

  always #5 clk = ~clk;

  // Board RAM model: two read pipelines of depth 2, ids 5,6,0,1,2,3,4,7 repeated, cursor bit on tile 0.
  logic [7:0] mem [16];
  logic [7:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;
  logic       reload = 1'b1;

  function automatic logic [7:0] init_word(input int i);
    logic [5:0] id;
    case (i % 8)
      0: id = 6'd5;  1: id = 6'd6;  2: id = 6'd0;  3: id = 6'd1;
      4: id = 6'd2;  5: id = 6'd3;  6: id = 6'd4;  default: id = 6'd7;
    endcase
    return {id, 1'b0, (i == 0)};
  endfunction

  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else begin
      if (ram1.weA) mem[ram1.addrA] <= ram1.writeA;
      if (ram1.weB) mem[ram1.addrB] <= ram1.writeB;
    end
    pa1 <= mem[ram1.addrA];
    pa2 <= pa1;
    pb1 <= mem[ram1.addrB];
    pb2 <= pb1;
  end
  assign ram1.readA = pa2;
  assign ram1.readB = pb2;
  assign ram2.readA = 8'h00;
  assign ram2.readB = 8'h00;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mv(input int dir);
    case (dir)
      0: arrowUp = 1'b1;  1: arrowDown = 1'b1;  2: arrowL = 1'b1;  default: arrowR = 1'b1;
    endcase
    step;
    arrowUp = 1'b0; arrowDown = 1'b0; arrowL = 1'b0; arrowR = 1'b0;
    step; step; step;
  endtask

  task automatic pick;
    select = 1'b1;
    step;
    select = 1'b0;
    step; step; step;
  endtask

  task automatic goto_tile(input int target);
    int n;
    n = 0;
    while (cur != target && n < 12) begin
      if (cur / 4 < target / 4) begin mv(1); cur += 4; end
      else if (cur / 4 > target / 4) begin mv(0); cur -= 4; end
      else if (cur % 4 < target % 4) begin mv(3); cur += 1; end
      else begin mv(2); cur -= 1; end
      n++;
    end
    checks++; if (cur != target) begin failures++; $display("FAIL goto_budget got=%0d exp=%0d", cur, target); end
  endtask

  task automatic test_reset;
    step; step;
    checks++; if (state1 !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state1); end
    checks++; if ({score1, matched1, go1, busy1} !== 14'd0) begin failures++; $display("FAIL rst_outputs got=%h exp=0", {score1, matched1, go1, busy1}); end
    checks++; if ({ram1.weA, ram1.weB, ram1.addrA, ram1.addrB, ram1.writeA, ram1.writeB} !== 26'd0) begin
      failures++; $display("FAIL rst_ram_port got=%h exp=0", {ram1.weA, ram1.weB, ram1.addrA, ram1.addrB, ram1.writeA, ram1.writeB}); end
    reset = 1'b0;
    reload = 1'b0;
    step;
  endtask

  task automatic test_start;
    inGameOn = 1'b1;
    #1;
    checks++; if (state1 !== 4'd0) begin failures++; $display("FAIL start_pre_edge got=%0d exp=0", state1); end
    step;
    checks++; if (state1 !== 4'd1 || busy1 !== 1'b0) begin failures++; $display("FAIL start_select got=%0d/%b exp=1/0", state1, busy1); end
  endtask

  task automatic test_move_wrap;
    arrowL = 1'b1;
    step;
    arrowL = 1'b0;
    checks++; if (state1 !== 4'd2 || ram1.addrA !== 4'd0 || ram1.addrB !== 4'd3) begin
      failures++; $display("FAIL mv_left_addr got=%0d a=%0d b=%0d exp=2 a=0 b=3", state1, ram1.addrA, ram1.addrB); end
    checks++; if (state2 !== 4'd1 || ram2.weA !== 1'b0) begin failures++; $display("FAIL clamp_stay got=%0d we=%b exp=1 we=0", state2, ram2.weA); end
    step;
    checks++; if (state1 !== 4'd2 || ram1.weA !== 1'b0) begin failures++; $display("FAIL mv_wait got=%0d we=%b exp=2 we=0", state1, ram1.weA); end
    step;
    checks++; if (state1 !== 4'd3 || {ram1.weA, ram1.weB} !== 2'b11 || ram1.writeA !== 8'h14 || ram1.writeB !== 8'h05) begin
      failures++; $display("FAIL mv_write got=%0d we=%b%b wa=%h wb=%h exp=3 we=11 wa=14 wb=05", state1, ram1.weA, ram1.weB, ram1.writeA, ram1.writeB); end
    checks++; if (ram2.weA !== 1'b0 || ram2.weB !== 1'b0) begin failures++; $display("FAIL clamp_no_we got=%b%b exp=00", ram2.weA, ram2.weB); end
    step;
    checks++; if (state1 !== 4'd1 || ram1.weA !== 1'b0 || mem[0] !== 8'h14 || mem[3] !== 8'h05) begin
      failures++; $display("FAIL mv_done got=%0d we=%b m0=%h m3=%h exp=1 we=0 m0=14 m3=05", state1, ram1.weA, mem[0], mem[3]); end
    arrowR = 1'b1;
    step;
    arrowR = 1'b0;
    checks++; if (ram1.addrA !== 4'd3 || ram1.addrB !== 4'd0) begin failures++; $display("FAIL mv_right_wrap got=a%0d b%0d exp=a3 b0", ram1.addrA, ram1.addrB); end
    checks++; if (state2 !== 4'd2 || ram2.addrA !== 4'd0 || ram2.addrB !== 4'd1) begin
      failures++; $display("FAIL clamp_cursor got=%0d a%0d b%0d exp=2 a0 b1", state2, ram2.addrA, ram2.addrB); end
    step; step;
    checks++; if (ram1.writeA !== 8'h04 || ram1.writeB !== 8'h15) begin failures++; $display("FAIL mv_right_data got=%h/%h exp=04/15", ram1.writeA, ram1.writeB); end
    step;
    cur = 0;
  endtask

  task automatic test_mismatch;
    int n;
    select = 1'b1;
    step;
    select = 1'b0;
    checks++; if (state1 !== 4'd4 || ram1.addrA !== 4'd0) begin failures++; $display("FAIL pick1_rd got=%0d a=%0d exp=4 a=0", state1, ram1.addrA); end
    step; step;
    checks++; if (state1 !== 4'd5 || ram1.weA !== 1'b1 || ram1.weB !== 1'b0 || ram1.writeA !== 8'h17) begin
      failures++; $display("FAIL pick1_wr got=%0d we=%b%b wa=%h exp=5 we=10 wa=17", state1, ram1.weA, ram1.weB, ram1.writeA); end
    step;
    checks++; if (state1 !== 4'd1) begin failures++; $display("FAIL pick1_back got=%0d exp=1", state1); end
    mv(3); cur = 1;
    select = 1'b1;
    step;
    select = 1'b0;
    step; step;
    checks++; if (state1 !== 4'd5 || ram1.writeA !== 8'h1b || ram1.weA !== 1'b1) begin
      failures++; $display("FAIL pick2_wr got=%0d wa=%h we=%b exp=5 wa=1b we=1", state1, ram1.writeA, ram1.weA); end
    step;
    n = 0;
    while (state1 === 4'd6 && n < 10) begin step; n++; end
    checks++; if (n != 4) begin failures++; $display("FAIL reveal_len got=%0d exp=4", n); end
    checks++; if (state1 !== 4'd7 || ram1.addrA !== 4'd0 || ram1.addrB !== 4'd1 || {ram1.weA, ram1.weB} !== 2'b11) begin
      failures++; $display("FAIL resolve_ctl got=%0d a=%0d b=%0d we=%b%b exp=7 a=0 b=1 we=11", state1, ram1.addrA, ram1.addrB, ram1.weA, ram1.weB); end
    checks++; if (ram1.writeA !== 8'h14 || ram1.writeB !== 8'h19) begin failures++; $display("FAIL resolve_data got=%h/%h exp=14/19", ram1.writeA, ram1.writeB); end
    step;
    checks++; if (score1 !== 8'd1 || matched1 !== 4'd0 || state1 !== 4'd1) begin
      failures++; $display("FAIL resolve_score got=s%0d m%0d st%0d exp=s1 m0 st1", score1, matched1, state1); end
  endtask

  task automatic test_flipped;
    pick;
    checks++; if (mem[1] !== 8'h1b || state1 !== 4'd1) begin failures++; $display("FAIL flip_first got=%h st%0d exp=1b st1", mem[1], state1); end
    select = 1'b1;
    step;
    select = 1'b0;
    checks++; if (state1 !== 4'd4) begin failures++; $display("FAIL flip_rd got=%0d exp=4", state1); end
    step; step;
    checks++; if (state1 !== 4'd5 || ram1.weA !== 1'b0 || ram1.weB !== 1'b0) begin
      failures++; $display("FAIL flip_no_we got=%0d we=%b%b exp=5 we=00", state1, ram1.weA, ram1.weB); end
    step;
    checks++; if (state1 !== 4'd1 || score1 !== 8'd1) begin failures++; $display("FAIL flip_back got=st%0d s%0d exp=st1 s1", state1, score1); end
  endtask

  task automatic test_reset_mid_reveal;
    mv(3); cur = 2;
    pick;
    step;
    checks++; if (state1 !== 4'd6) begin failures++; $display("FAIL mid_reveal_setup got=%0d exp=6", state1); end
    reset = 1'b1;
    #1;
    checks++; if (state1 !== 4'd0 || score1 !== 8'd0 || busy1 !== 1'b0 || go1 !== 1'b0) begin
      failures++; $display("FAIL rst_async got=st%0d s%0d b%b g%b exp=st0 s0 b0 g0", state1, score1, busy1, go1); end
    checks++; if (ram1.addrA !== 4'd0 || ram1.addrB !== 4'd0 || ram1.weA !== 1'b0) begin
      failures++; $display("FAIL rst_async_ram got=a%0d b%0d we%b exp=a0 b0 we0", ram1.addrA, ram1.addrB, ram1.weA); end
    #2;
    reset = 1'b0;
    reload = 1'b1;
    step;
    reload = 1'b0;
    checks++; if (state1 !== 4'd1 || state2 !== 4'd1) begin failures++; $display("FAIL rst_restart got=%0d/%0d exp=1/1", state1, state2); end
    cur = 0;
  endtask

  task automatic test_priority_quit;
    select = 1'b1;
    arrowUp = 1'b1;
    step;
    select = 1'b0;
    arrowUp = 1'b0;
    checks++; if (state1 !== 4'd4 || ram1.addrA !== 4'd0) begin failures++; $display("FAIL sel_priority got=%0d a=%0d exp=4 a=0", state1, ram1.addrA); end
    step; step;
    checks++; if (state1 !== 4'd5 || ram1.weA !== 1'b1) begin failures++; $display("FAIL quit_pre got=%0d we=%b exp=5 we=1", state1, ram1.weA); end
    userquit = 1'b1;
    #1;
    checks++; if (ram1.weA !== 1'b0 || ram1.weB !== 1'b0) begin failures++; $display("FAIL quit_we_gate got=%b%b exp=00", ram1.weA, ram1.weB); end
    step;
    checks++; if (state1 !== 4'd0 || mem[0] !== 8'h15) begin failures++; $display("FAIL quit_idle got=st%0d m0=%h exp=st0 m0=15", state1, mem[0]); end
    userquit = 1'b0;
    step;
    checks++; if (state1 !== 4'd1 || score1 !== 8'd0) begin failures++; $display("FAIL quit_resume got=st%0d s%0d exp=st1 s0", state1, score1); end
  endtask

  task automatic test_full_game;
    int n;
    for (int i = 0; i < 8; i++) begin
      goto_tile(i);
      pick;
      goto_tile(i + 8);
      pick;
      n = 0;
      while (state1 === 4'd6 && n < 10) begin step; n++; end
      checks++; if (state1 !== 4'd7 || ram1.weA !== 1'b0 || ram1.weB !== 1'b0) begin
        failures++; $display("FAIL match_resolve pair=%0d got=st%0d we=%b%b exp=st7 we=00", i, state1, ram1.weA, ram1.weB); end
      step;
      checks++; if (matched1 !== 4'(i + 1) || score1 !== 8'(i + 1)) begin
        failures++; $display("FAIL match_count pair=%0d got=m%0d s%0d exp=%0d", i, matched1, score1, i + 1); end
    end
    checks++; if (state1 !== 4'd8 || go1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++; $display("FAIL done_state got=st%0d g%b b%b exp=st8 g1 b0", state1, go1, busy1); end
    step;
    checks++; if (state1 !== 4'd8 || matched1 !== 4'd8 || score1 !== 8'd8) begin
      failures++; $display("FAIL done_frozen got=st%0d m%0d s%0d exp=st8 m8 s8", state1, matched1, score1); end
    inGameOn = 1'b0;
    step;
    checks++; if (state1 !== 4'd0 || go1 !== 1'b0) begin failures++; $display("FAIL done_exit got=st%0d g%b exp=st0 g0", state1, go1); end
  endtask

  initial begin
    test_reset;
    test_start;
    test_move_wrap;
    test_mismatch;
    test_flipped;
    test_reset_mid_reveal;
    test_priority_quit;
    test_full_game;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
